// File: rtl/divider_err_stats.sv
// Windowed error statistics between approximate and accurate divider quotients.
// Accumulates 2^LOG2_N accepted samples, then publishes results with a one-cycle done pulse.
module divider_err_stats #(
  parameter int unsigned LOG2_N = 8,
  parameter int unsigned THRESH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          app_q,
  input  logic [7:0]          acc_q,
  output logic                busy,
  output logic                done,
  output logic [7:0]          max_err,
  output logic [8+LOG2_N-1:0] sum_err,
  output logic [7:0]          mean_err,
  output logic [LOG2_N:0]     mis_cnt,
  output logic [LOG2_N:0]     over_cnt,
  output logic [LOG2_N:0]     under_cnt,
  output logic [LOG2_N:0]     thr_cnt
);

  localparam int unsigned SW = 8 + LOG2_N;
  localparam int unsigned CW = LOG2_N + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t        state_q;
  logic [SW-1:0] sum_q, sum_d;
  logic [7:0]    max_q, max_d, abs_err;
  logic [CW-1:0] mis_q, mis_d, over_q, over_d, under_q, under_d, thr_q, thr_d, cnt_q, cnt_d;
  logic          is_over, is_under, is_thr;

  always_comb begin
    is_over  = app_q > acc_q;
    is_under = app_q < acc_q;
    abs_err  = is_over ? (app_q - acc_q) : (acc_q - app_q);
    is_thr   = abs_err > 8'(THRESH);
    sum_d    = sum_q + SW'(abs_err);
    max_d    = (abs_err > max_q) ? abs_err : max_q;
    mis_d    = mis_q + CW'(is_over | is_under);
    over_d   = over_q + CW'(is_over);
    under_d  = under_q + CW'(is_under);
    thr_d    = thr_q + CW'(is_thr);
    cnt_d    = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      max_q     <= '0;
      mis_q     <= '0;
      over_q    <= '0;
      under_q   <= '0;
      thr_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      max_err   <= '0;
      sum_err   <= '0;
      mean_err  <= '0;
      mis_cnt   <= '0;
      over_cnt  <= '0;
      under_cnt <= '0;
      thr_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        // start behaves identically in IDLE and ACCUM: clear and (re)enter ACCUM
        IDLE, ACCUM: begin
          if (start) begin
            sum_q   <= '0;
            max_q   <= '0;
            mis_q   <= '0;
            over_q  <= '0;
            under_q <= '0;
            thr_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= ACCUM;
          end else if (state_q == ACCUM && in_valid) begin
            sum_q   <= sum_d;
            max_q   <= max_d;
            mis_q   <= mis_d;
            over_q  <= over_d;
            under_q <= under_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            if (cnt_q == LAST) begin
              max_err   <= max_d;
              sum_err   <= sum_d;
              mean_err  <= sum_d[SW-1:LOG2_N];
              mis_cnt   <= mis_d;
              over_cnt  <= over_d;
              under_cnt <= under_d;
              thr_cnt   <= thr_d;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_q   <= REPORT;
            end
          end
        end
        REPORT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_err_stats.sv
// Self-checking bench for divider_err_stats (LOG2_N=2, THRESH=2) against an arithmetic window model.
module tb_divider_err_stats;

  localparam int N   = 2;
  localparam int WIN = 4;
  localparam int THR = 2;
  localparam int VW  = 8 + (8 + N) + 8 + 4 * (N + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic [7:0]     app_q = '0;
  logic [7:0]     acc_q = '0;
  logic           busy, done;
  logic [7:0]     max_err, mean_err;
  logic [8+N-1:0] sum_err;
  logic [N:0]     mis_cnt, over_cnt, under_cnt, thr_cnt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int q_app[$];
  int q_acc[$];

  logic [VW-1:0] obs;
  assign obs = {max_err, sum_err, mean_err, mis_cnt, over_cnt, under_cnt, thr_cnt};

  divider_err_stats #(.LOG2_N(N), .THRESH(THR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .app_q(app_q), .acc_q(acc_q), .busy(busy), .done(done),
    .max_err(max_err), .sum_err(sum_err), .mean_err(mean_err),
    .mis_cnt(mis_cnt), .over_cnt(over_cnt), .under_cnt(under_cnt), .thr_cnt(thr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // Statistics of the samples in q_app/q_acc, computed with plain integer arithmetic.
  function automatic logic [VW-1:0] model();
    int mx = 0, sum = 0, mis = 0, ov = 0, un = 0, th = 0, e;
    foreach (q_app[i]) begin
      e = (q_app[i] > q_acc[i]) ? q_app[i] - q_acc[i] : q_acc[i] - q_app[i];
      sum += e;
      if (e > mx) mx = e;
      if (q_app[i] != q_acc[i]) mis++;
      if (q_app[i] > q_acc[i]) ov++;
      if (q_app[i] < q_acc[i]) un++;
      if (e > THR) th++;
    end
    return {8'(mx), 10'(sum), 8'(sum / WIN), 3'(mis), 3'(ov), 3'(un), 3'(th)};
  endfunction

  task automatic pulse_start(input bit v, input int a, input int b);
    start = 1'b1; in_valid = v; app_q = 8'(a); acc_q = 8'(b);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  // Drives the queued samples with 0..gapmax idle cycles before each; returns at the negedge after the last accept.
  task automatic drive_samples(input int gapmax);
    foreach (q_app[i]) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gapmax, 0)) @(negedge clk);
      in_valid = 1'b1; app_q = 8'(q_app[i]); acc_q = 8'(q_acc[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic set_samples(input int a0, b0, a1, b1, a2, b2, a3, b3);
    q_app = '{a0, a1, a2, a3};
    q_acc = '{b0, b1, b2, b3};
  endtask

  task automatic test_reset();
    @(posedge clk); #2 rst_n = 1'b0; #1;
    checks++;
    if ({busy, done, obs} !== '0) begin
      errors++; $display("FAIL reset_async: got %h exp 0", {busy, done, obs});
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_basic(input int gapmax, input string nm);
    int dc;
    set_samples(10, 10, 12, 10, 7, 10, 20, 16);
    pulse_start(1'b0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_after_start: got %b exp 1", nm, busy); end
    dc = done_cnt;
    drive_samples(gapmax);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || done_cnt !== dc) begin
      errors++; $display("FAIL %s_done_timing: done=%b busy=%b early=%0d exp done=1 busy=0 early=0", nm, done, busy, done_cnt - dc);
    end
    checks++;
    if (obs !== model()) begin errors++; $display("FAIL %s_stats_model: got %h exp %h", nm, obs, model()); end
    checks++;
    if (obs !== {8'd4, 10'd9, 8'd2, 3'd3, 3'd2, 3'd1, 3'd2}) begin
      errors++; $display("FAIL %s_stats_const: got %h exp %h", nm, obs, {8'd4, 10'd9, 8'd2, 3'd3, 3'd2, 3'd1, 3'd2});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_cnt !== dc + 1) begin
      errors++; $display("FAIL %s_done_pulse: done=%b pulses=%0d exp done=0 pulses=1", nm, done, done_cnt - dc);
    end
  endtask

  task automatic test_restart();
    logic [VW-1:0] prev;
    int dc;
    prev = obs;
    dc = done_cnt;
    pulse_start(1'b1, 255, 0);
    q_app = '{200, 0}; q_acc = '{0, 200};
    drive_samples(0);
    pulse_start(1'b1, 200, 0);
    checks++;
    if (busy !== 1'b1 || obs !== prev) begin
      errors++; $display("FAIL restart_hold: busy=%b got %h exp busy=1 %h", busy, obs, prev);
    end
    set_samples(5, 5, 5, 5, 5, 5, 5, 5);
    drive_samples(1);
    checks++;
    if (done !== 1'b1 || obs !== model() || obs !== '0) begin
      errors++; $display("FAIL restart_stats: done=%b got %h exp done=1 %h", done, obs, model());
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== dc + 1 || obs !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL restart_idle_hold: pulses=%0d got %h busy=%b exp pulses=1 0 busy=0", done_cnt - dc, obs, busy);
    end
  endtask

  task automatic test_saturation();
    set_samples(255, 0, 255, 0, 255, 0, 255, 0);
    pulse_start(1'b0, 0, 0);
    drive_samples(0);
    checks++;
    if (done !== 1'b1 || obs !== {8'd255, 10'd1020, 8'd255, 3'd4, 3'd4, 3'd0, 3'd4}) begin
      errors++; $display("FAIL saturation: done=%b got %h exp %h", done, obs, {8'd255, 10'd1020, 8'd255, 3'd4, 3'd4, 3'd0, 3'd4});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int dc, a, b;
    for (int w = 0; w < 8; w++) begin
      q_app.delete(); q_acc.delete();
      for (int i = 0; i < WIN; i++) begin
        a = $urandom_range(255, 0);
        case ($urandom_range(3, 0))
          0: b = a;
          1: b = (a + $urandom_range(5, 0)) % 256;
          default: b = $urandom_range(255, 0);
        endcase
        q_app.push_back(a); q_acc.push_back(b);
      end
      pulse_start(1'b0, 0, 0);
      dc = done_cnt;
      drive_samples(3);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || done_cnt !== dc || obs !== model()) begin
        errors++; $display("FAIL random_w%0d: done=%b busy=%b got %h exp %h", w, done, busy, obs, model());
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || done_cnt !== dc + 1) begin
        errors++; $display("FAIL random_start_in_report_w%0d: busy=%b done=%b exp busy=0 done=0", w, busy, done);
      end
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    dc = done_cnt;
    pulse_start(1'b0, 0, 0);
    q_app = '{100, 3}; q_acc = '{1, 90};
    drive_samples(0);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    checks++;
    if ({busy, done, obs} !== '0) begin
      errors++; $display("FAIL reset_mid_clear: got %h exp 0", {busy, done, obs});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; app_q = 8'($urandom_range(255, 0)); acc_q = 8'($urandom_range(255, 0));
      @(negedge clk);
      checks++;
      if ({busy, done, obs} !== '0) begin
        errors++; $display("FAIL idle_valid_ignored_%0d: got %h exp 0", i, {busy, done, obs});
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done_cnt !== dc) begin errors++; $display("FAIL reset_mid_no_done: pulses=%0d exp 0", done_cnt - dc); end
  endtask

  initial begin
    test_reset();
    test_basic(0, "back_to_back");
    test_basic(3, "gaps");
    test_restart();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
